// File: rtl/herald_host_bridge.sv
// Host-side initiator for the Herald byte-strobe coprocessor bus: write cmd/operands, poll BUSY, read result.
// Optional HERALD_HOST_BRIDGE_SYNC_EN: 2-flop synchroniser on bus_din for an asynchronous coprocessor clock.
module herald_host_bridge #(
  parameter int STROBE_CYCLES  = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [23:0] req_a,
  input  logic [23:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [71:0] rsp_data,
  output logic [3:0]  rsp_nbytes,
  output logic        rsp_err,
  output logic [7:0]  bus_dout,
  output logic        bus_wr,
  output logic        bus_rd,
  input  logic [7:0]  bus_din,
  output logic        active
);
  localparam logic [2:0] S_IDLE   = 3'd0,
                         S_WR_HI  = 3'd1,
                         S_WR_LO  = 3'd2,
                         S_SETTLE = 3'd3,
                         S_POLL   = 3'd4,
                         S_RD_HI  = 3'd5,
                         S_RD_LO  = 3'd6,
                         S_RESP   = 3'd7;

  logic [7:0] din;
`ifdef HERALD_HOST_BRIDGE_SYNC_EN
  localparam int SETTLE_EFF = SETTLE_CYCLES + 2;
  logic [7:0] din_s1, din_s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_s1 <= '0;
      din_s2 <= '0;
    end else begin
      din_s1 <= bus_din;
      din_s2 <= din_s1;
    end
  end
  assign din = din_s2;
  // Read data must be presented early enough in the strobe to clear the synchroniser.
  always @(posedge clk)
    if (rst_n) assert (STROBE_CYCLES >= 4) else $error("STROBE_CYCLES must be >= 4 with synchroniser");
`else
  localparam int SETTLE_EFF = SETTLE_CYCLES;
  assign din = bus_din;
`endif

  localparam int CW = $clog2(TIMEOUT_CYCLES + 32);
  localparam logic [CW-1:0] T_STB = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] T_GAP = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] T_SET = CW'(((SETTLE_EFF > 0) ? SETTLE_EFF : 1) - 1);
  localparam logic [CW-1:0] T_TMO = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]      state, nxt;
  logic [CW-1:0]   cnt;
  logic [3:0]      idx, idx_n, nwr, nrd, dec_nwr, dec_nrd;
  logic [6:0][7:0] wb;
  logic            dec_ok, tmo, last_wr, last_rd;

  // Byte counts include the command byte on the write side.
  always_comb begin
    dec_ok  = 1'b1;
    dec_nwr = 4'd7;
    dec_nrd = 4'd3;
    case (req_cmd)
      8'h10:                      begin dec_nwr = 4'd4; dec_nrd = 4'd6; end
      8'h11, 8'h12, 8'h20, 8'h21: ;
      8'h13:                      dec_nrd = 4'd9;
      8'h23:                      dec_nwr = 4'd4;
      8'h22:                      begin dec_nwr = 4'd1; dec_nrd = 4'd0; end
      default:                    begin dec_ok = 1'b0; dec_nwr = 4'd0; dec_nrd = 4'd0; end
    endcase
  end

  assign idx_n   = idx + 4'd1;
  assign last_wr = (idx == nwr - 4'd1);
  assign last_rd = (idx == nrd - 4'd1);

  always_comb begin
    nxt = state;
    tmo = 1'b0;
    case (state)
      S_IDLE:   if (req_valid) nxt = dec_ok ? S_WR_HI : S_RESP;
      S_WR_HI:  if (cnt == T_STB) nxt = S_WR_LO;
      S_WR_LO:  if (cnt == T_GAP) nxt = last_wr ? S_SETTLE : S_WR_HI;
      S_SETTLE: if (cnt == T_SET) nxt = S_POLL;
      S_POLL:
        if (!din[7]) nxt = (nrd == 4'd0) ? S_RESP : S_RD_HI;
        else if (cnt == T_TMO) begin
          nxt = S_RESP;
          tmo = 1'b1;
        end
      S_RD_HI:  if (cnt == T_STB) nxt = S_RD_LO;
      S_RD_LO:  if (cnt == T_GAP) nxt = last_rd ? S_RESP : S_RD_HI;
      S_RESP:   if (rsp_ready) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      nwr        <= '0;
      nrd        <= '0;
      wb         <= '0;
      req_ready  <= 1'b1;
      active     <= 1'b0;
      bus_wr     <= 1'b0;
      bus_rd     <= 1'b0;
      bus_dout   <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_nbytes <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= (nxt != state || state == S_IDLE || state == S_RESP) ? '0 : cnt + 1'b1;
      req_ready <= (nxt == S_IDLE);
      active    <= (nxt != S_IDLE);
      bus_wr    <= (nxt == S_WR_HI);
      bus_rd    <= (nxt == S_RD_HI);
      rsp_valid <= (nxt == S_RESP);
      case (state)
        S_IDLE:
          if (req_valid) begin
            wb         <= {req_b, req_a, req_cmd};
            nwr        <= dec_nwr;
            nrd        <= dec_nrd;
            idx        <= '0;
            rsp_data   <= '0;
            rsp_nbytes <= '0;
            rsp_err    <= !dec_ok;
            if (dec_ok) bus_dout <= req_cmd;
          end
        S_WR_LO:
          if (cnt == T_GAP) begin
            if (last_wr) idx <= '0;
            else begin
              idx      <= idx_n;
              bus_dout <= wb[idx_n[2:0]];
            end
          end
        S_POLL:   if (tmo) rsp_err <= 1'b1;
        S_RD_HI:  if (cnt == T_STB) rsp_data[idx*8 +: 8] <= din;
        S_RD_LO:
          if (cnt == T_GAP) begin
            if (last_rd) rsp_nbytes <= nrd;
            else idx <= idx_n;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_herald_host_bridge.sv
// Directed bench for herald_host_bridge with a same-clock coprocessor responder model.
`timescale 1ns/1ps
module tb_herald_host_bridge;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, rsp_ready = 1'b0;
  logic [7:0]  req_cmd = '0;
  logic [23:0] req_a = '0, req_b = '0;
  logic        req_ready, rsp_valid, rsp_err, bus_wr, bus_rd, active;
  logic [71:0] rsp_data;
  logic [3:0]  rsp_nbytes;
  logic [7:0]  bus_dout, bus_din;

  always #5 clk = ~clk;

  herald_host_bridge #(.STROBE_CYCLES(2), .GAP_CYCLES(2), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_nbytes(rsp_nbytes), .rsp_err(rsp_err), .bus_dout(bus_dout), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_din(bus_din), .active(active)
  );

  // Responder: edge-detects strobes, logs written bytes, busy for a while after each write.
  logic        clr = 1'b0, hang = 1'b0, busy = 1'b0, wr_q = 1'b0, rd_q = 1'b0;
  logic [71:0] rb = '0;
  logic [7:0]  rdata = '0;
  logic [3:0]  bcnt = '0;
  logic [55:0] wlog = '0;
  int          wr_n = 0, rd_n = 0;

  assign bus_din = (bus_rd && rd_q) ? rdata : {busy, 7'b0};

  always @(posedge clk) begin
    wr_q <= bus_wr;
    rd_q <= bus_rd;
    if (clr) begin
      wr_n <= 0; rd_n <= 0; wlog <= '0; busy <= 1'b0; bcnt <= '0;
    end else begin
      if (bus_wr && !wr_q) begin
        if (wr_n < 7) wlog[wr_n*8 +: 8] <= bus_dout;
        wr_n <= wr_n + 1;
        busy <= 1'b1;
        bcnt <= 4'd6;
      end else if (bcnt != 0) bcnt <= bcnt - 4'd1;
      else if (!hang) busy <= 1'b0;
      if (bus_rd && !rd_q) begin
        if (rd_n < 9) rdata <= rb[rd_n*8 +: 8];
        rd_n <= rd_n + 1;
      end
    end
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] a, b;
    logic [71:0] rb;
    int          nwr;
    logic [55:0] wb;
    int          nrd;
    logic [71:0] data;
    logic [3:0]  nb;
    logic        err;
    logic        hang;
    int          lat;
  } vec_t;
  vec_t v[8];

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic start_req(input int i);
    @(negedge clk) clr = 1'b1; hang = v[i].hang; rb = v[i].rb;
    @(negedge clk) clr = 1'b0;
    chk("idle_ready", {71'b0, req_ready}, 72'd1);
    req_valid = 1'b1; req_cmd = v[i].cmd; req_a = v[i].a; req_b = v[i].b;
    @(negedge clk) req_valid = 1'b0; req_cmd = '0; req_a = '0; req_b = '0;
  endtask

  task automatic run_vec(input int i);
    int n;
    logic ok;
    start_req(i);
    n = 1; ok = 1'b1;
    while (!rsp_valid && n < 400) begin
      if ((bus_wr && bus_rd) || !active || req_ready) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_rsp_seen", i), {71'b0, rsp_valid}, 72'd1);
    if (v[i].lat != 0) chk($sformatf("v%0d_latency", i), 72'(n), 72'(v[i].lat));
    chk($sformatf("v%0d_busy_phase", i), {71'b0, ok}, 72'd1);
    chk($sformatf("v%0d_data", i), rsp_data, v[i].data);
    chk($sformatf("v%0d_nbytes", i), {68'b0, rsp_nbytes}, {68'b0, v[i].nb});
    chk($sformatf("v%0d_err", i), {71'b0, rsp_err}, {71'b0, v[i].err});
    chk($sformatf("v%0d_wr_pulses", i), 72'(wr_n), 72'(v[i].nwr));
    chk($sformatf("v%0d_wr_bytes", i), {16'b0, wlog}, {16'b0, v[i].wb});
    chk($sformatf("v%0d_rd_pulses", i), 72'(rd_n), 72'(v[i].nrd));
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== v[i].data || rsp_nbytes !== v[i].nb || rsp_err !== v[i].err || req_ready)
        ok = 1'b0;
    end
    chk($sformatf("v%0d_hold_stable", i), {71'b0, ok}, 72'd1);
    rsp_ready = 1'b1;
    @(negedge clk) rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_drop", i), {71'b0, rsp_valid}, 72'd0);
    chk($sformatf("v%0d_ready_back", i), {70'b0, req_ready, active}, 72'b10);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //      cmd    a          b          rb                    nwr wb                  nrd data                  nb     err   hang  lat
    v[0] = '{8'h10, 24'h000C91, 24'hABCDEF, 72'hEEEEEE000B50000B50, 4, 56'h000000000C9110, 6, 72'h000B50000B50,     4'd6, 1'b0, 1'b0, 0};
    v[1] = '{8'h11, 24'h001000, 24'h001000, 72'hFFFFFFFFFFFF000C91, 7, 56'h00100000100011, 3, 72'h000C91,           4'd3, 1'b0, 1'b0, 0};
    v[2] = '{8'h22, 24'h123456, 24'h654321, 72'hDDDDDDDDDDDDDDDDDD, 1, 56'h00000000000022, 0, 72'h0,                4'd0, 1'b0, 1'b0, 0};
    v[3] = '{8'h23, 24'h002000, 24'h123456, 72'hBBBBBBBBBBBB817F80, 4, 56'h00000000200023, 3, 72'h817F80,           4'd3, 1'b0, 1'b0, 0};
    v[4] = '{8'h12, 24'h000001, 24'h000002, 72'hCCCCCCCCCCCCCCCCCC, 7, 56'h00000200000112, 0, 72'h0,                4'd0, 1'b1, 1'b1, 95};
    v[5] = '{8'h55, 24'h111111, 24'h222222, 72'hAAAAAAAAAAAAAAAAAA, 0, 56'h0,              0, 72'h0,                4'd0, 1'b1, 1'b0, 1};
    v[6] = '{8'h13, 24'h030201, 24'h060504, 72'hA9A8A7A6A5A4A3A2A1, 7, 56'h06050403020113, 9, 72'hA9A8A7A6A5A4A3A2A1, 4'd9, 1'b0, 1'b0, 0};
    v[7] = '{8'h21, 24'hFFFFFF, 24'h800000, 72'hCCCCCCCCCCCC123456, 7, 56'h800000FFFFFF21, 3, 72'h123456,           4'd3, 1'b0, 1'b0, 0};

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {71'b0, req_ready}, 72'd1);
    chk("rst_rsp_valid", {71'b0, rsp_valid}, 72'd0);
    chk("rst_rsp_data", rsp_data, 72'd0);
    chk("rst_rsp_nbytes", {68'b0, rsp_nbytes}, 72'd0);
    chk("rst_rsp_err", {71'b0, rsp_err}, 72'd0);
    chk("rst_bus_dout", {64'b0, bus_dout}, 72'd0);
    chk("rst_strobes", {70'b0, bus_wr, bus_rd}, 72'd0);
    chk("rst_active", {71'b0, active}, 72'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset while a read strobe is high must drop it asynchronously.
    begin
      int n;
      start_req(0);
      n = 0;
      while (!bus_rd && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("mid_rd_seen", {71'b0, bus_rd}, 72'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rd_drop", {71'b0, bus_rd}, 72'd0);
      chk("mid_rd_ready", {70'b0, req_ready, active}, 72'b10);
      chk("mid_rd_nostb", {71'b0, bus_wr}, 72'd0);
      @(negedge clk) rst_n = 1'b1;
    end
    run_vec(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
